// File: rtl/aes256_key_rev_sched.sv
// AES-256 key schedule emitting the 15 round keys in decryption order (14..0).
// A window of 8 schedule words walks forward to the end of the expansion and
// then steps backward one round key at a time, so no round-key RAM is needed.

// One AES S-box lookup, computed as GF(2^8) inverse (x^254) plus the affine map.
module aes256_key_rev_sched_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] s_o
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] x2, x3, x6, x7, x14, x15, x30, x31, x62, x63, x126, x127, inv;

    // Square-and-multiply chain to x^254 (inverse, with 0 mapping to 0), then affine transform
    always_comb begin
        x2   = gf_mul(a_i, a_i);
        x3   = gf_mul(x2, a_i);
        x6   = gf_mul(x3, x3);
        x7   = gf_mul(x6, a_i);
        x14  = gf_mul(x7, x7);
        x15  = gf_mul(x14, a_i);
        x30  = gf_mul(x15, x15);
        x31  = gf_mul(x30, a_i);
        x62  = gf_mul(x31, x31);
        x63  = gf_mul(x62, a_i);
        x126 = gf_mul(x63, x63);
        x127 = gf_mul(x126, a_i);
        inv  = gf_mul(x127, x127);
        s_o  = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module aes256_key_rev_sched #(
    parameter bit CLEAR_ON_DONE = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] key,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_idx,
    output logic         busy,
    output logic         done
);
    typedef enum logic [1:0] {IDLE, FWD, EMIT, EMIT0} state_t;

    state_t             state_q, state_d;
    logic [0:7][31:0]   win_q, win_d;
    logic [3:0]         k_q, k_d;
    logic               rk_valid_q, rk_valid_d;
    logic [127:0]       rk_data_q, rk_data_d;
    logic [3:0]         rk_idx_q, rk_idx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [31:0] sub_in, sub_out, t_word;
    logic [7:0]  rcon;
    logic        use_rot;
    logic        hs;
    logic [31:0] fw0, fw1, fw2, fw3;
    logic [31:0] bw0, bw1, bw2, bw3;

    // Forward step transforms W[7]; backward step transforms W[3]. The
    // RotWord+Rcon case applies when the word index is a multiple of 8, which
    // is k even going forward and k odd going backward; in both cases the
    // Rcon exponent works out to k/2.
    assign sub_in  = (state_q == FWD) ? win_q[7] : win_q[3];
    assign use_rot = (state_q == FWD) ^ k_q[0];
    assign rcon    = 8'h01 << k_q[3:1];

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes256_key_rev_sched_sbox u_sbox (
            .a_i (sub_in[8*b +: 8]),
            .s_o (sub_out[8*b +: 8])
        );
    end

    assign t_word = use_rot ? ({sub_out[23:0], sub_out[31:24]} ^ {rcon, 24'h0}) : sub_out;

    assign fw0 = win_q[0] ^ t_word;
    assign fw1 = win_q[1] ^ fw0;
    assign fw2 = win_q[2] ^ fw1;
    assign fw3 = win_q[3] ^ fw2;

    assign bw3 = win_q[7] ^ win_q[6];
    assign bw2 = win_q[6] ^ win_q[5];
    assign bw1 = win_q[5] ^ win_q[4];
    assign bw0 = win_q[4] ^ t_word;

    assign hs = rk_valid_q & rk_ready;

    // Next-state, window movement and the output values they imply
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        k_d     = k_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    win_d   = key;
                    k_d     = '0;
                    state_d = FWD;
                end
            end
            FWD: begin
                win_d = {win_q[4], win_q[5], win_q[6], win_q[7], fw0, fw1, fw2, fw3};
                k_d   = k_q + 4'd1;
                if (k_q == 4'd12) state_d = EMIT;
            end
            EMIT: begin
                if (hs) begin
                    if (k_q == 4'd0) begin
                        state_d = EMIT0;
                    end else begin
                        win_d = {bw0, bw1, bw2, bw3, win_q[0], win_q[1], win_q[2], win_q[3]};
                        k_d   = k_q - 4'd1;
                    end
                end
            end
            EMIT0: begin
                if (hs) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    if (CLEAR_ON_DONE) win_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        rk_valid_d = (state_d == EMIT) || (state_d == EMIT0);
        busy_d     = (state_d != IDLE);
        rk_idx_d   = (state_d == EMIT) ? k_d + 4'd1 : 4'd0;
        if (state_d == EMIT)
            rk_data_d = {win_d[4], win_d[5], win_d[6], win_d[7]};
        else if (state_d == EMIT0)
            rk_data_d = {win_d[0], win_d[1], win_d[2], win_d[3]};
        else
            rk_data_d = '0;
    end

    // State, window and registered outputs with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            win_q      <= '0;
            k_q        <= '0;
            rk_valid_q <= 1'b0;
            rk_data_q  <= '0;
            rk_idx_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            k_q        <= k_d;
            rk_valid_q <= rk_valid_d;
            rk_data_q  <= rk_data_d;
            rk_idx_q   <= rk_idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign rk_valid = rk_valid_q;
    assign rk_data  = rk_data_q;
    assign rk_idx   = rk_idx_q;
    assign busy     = busy_q;
    assign done     = done_q;
endmodule
